// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared types and constants for the SHA-256 round controller
//
// Purpose: FSM state encoding, round-count defaults, and the SHA-256 initial
// hash values used by the datapath IV mux.
package sha256_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_ROUND  = 3'd2,
    ST_UPDATE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int NUM_ROUNDS_DEF = 64;
  // Rounds below this index take W directly from the message block.
  localparam int W_MSG_WORDS    = 16;

  localparam logic [31:0] SHA256_IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

endpackage

// File: rtl/sha256_round_cnt.sv
// rtl/sha256_round_cnt.sv - clear/enable round counter with terminal-count flag
//
// Purpose: counts compression rounds; tc marks the last round.
// Ports:
//   CLK   in   clock, rising edge
//   RST   in   synchronous active-high reset
//   clr   in   clear count to 0 (has priority over en)
//   en    in   increment count
//   count out  current round number
//   tc    out  count == NUM_ROUNDS-1
module sha256_round_cnt
  import sha256_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
  parameter int IDX_W      = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             en,
  output logic [IDX_W-1:0] count,
  output logic             tc
);

  logic [IDX_W-1:0] count_q;
  logic [IDX_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == IDX_W'(NUM_ROUNDS - 1));

endmodule

// File: rtl/sha256_round_ctrl.sv
// rtl/sha256_round_ctrl.sv - SHA-256 block/round sequencing FSM
//
// Purpose: accepts message blocks, issues IV/working-register loads, steps the
// compression rounds, triggers H accumulation and presents the final digest.
// Ports:
//   CLK, RST              clock / synchronous active-high reset
//   blk_valid/first/last  block handshake from the padder; blk_ready back
//   abort                 synchronous cancel, returns to IDLE
//   iv_load, wk_load      H/working-register load strobes
//   round_en, round_idx   round strobe and K/W index; w_sel picks W source
//   h_update              H accumulation strobe
//   digest_valid/ready    final digest handshake
//   busy                  not IDLE
// All outputs are flops computed from the next state, so no input reaches an
// output combinationally.
module sha256_round_ctrl
  import sha256_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
  parameter int IDX_W      = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             blk_valid,
  input  logic             blk_first,
  input  logic             blk_last,
  output logic             blk_ready,
  input  logic             abort,
  output logic             iv_load,
  output logic             wk_load,
  output logic             round_en,
  output logic [IDX_W-1:0] round_idx,
  output logic             w_sel,
  output logic             h_update,
  output logic             digest_valid,
  input  logic             digest_ready,
  output logic             busy
);

  state_e state_q, state_d;
  logic   first_q, first_d;
  logic   last_q, last_d;

  logic             blk_ready_q, iv_load_q, wk_load_q, round_en_q;
  logic [IDX_W-1:0] round_idx_q;
  logic             w_sel_q, h_update_q, digest_valid_q, busy_q;

  logic             cnt_clr, cnt_en, cnt_tc;
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] idx_next;

  // Held at zero outside ROUND, so every ROUND pass starts from round 0;
  // stops at the terminal count so it never wraps.
  assign cnt_clr = (state_q != ST_ROUND);
  assign cnt_en  = (state_q == ST_ROUND) && !cnt_tc;

  sha256_round_cnt #(
    .NUM_ROUNDS (NUM_ROUNDS),
    .IDX_W      (IDX_W)
  ) u_round_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (cnt),
    .tc    (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    first_d = first_q;
    last_d  = last_q;
    if (abort) begin
      state_d = ST_IDLE;
      first_d = 1'b0;
      last_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (blk_valid) begin
            first_d = blk_first;
            last_d  = blk_last;
            state_d = ST_INIT;
          end
        end
        ST_INIT:   state_d = ST_ROUND;
        ST_ROUND:  if (cnt_tc) state_d = ST_UPDATE;
        ST_UPDATE: state_d = last_q ? ST_DONE : ST_IDLE;
        ST_DONE:   if (digest_ready) state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Counter value seen in the next cycle when that cycle is a ROUND cycle:
  // ROUND is entered only from INIT (count 0) or continues from ROUND (+1).
  assign idx_next = (state_q == ST_ROUND) ? cnt + 1'b1 : '0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= ST_IDLE;
      first_q        <= 1'b0;
      last_q         <= 1'b0;
      blk_ready_q    <= 1'b1;
      iv_load_q      <= 1'b0;
      wk_load_q      <= 1'b0;
      round_en_q     <= 1'b0;
      round_idx_q    <= '0;
      w_sel_q        <= 1'b0;
      h_update_q     <= 1'b0;
      digest_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      first_q        <= first_d;
      last_q         <= last_d;
      blk_ready_q    <= (state_d == ST_IDLE);
      iv_load_q      <= (state_d == ST_INIT) && first_d;
      wk_load_q      <= (state_d == ST_INIT);
      round_en_q     <= (state_d == ST_ROUND);
      round_idx_q    <= (state_d == ST_ROUND) ? idx_next : '0;
      w_sel_q        <= (state_d == ST_ROUND) && (idx_next >= IDX_W'(W_MSG_WORDS));
      h_update_q     <= (state_d == ST_UPDATE);
      digest_valid_q <= (state_d == ST_DONE);
      busy_q         <= (state_d != ST_IDLE);
    end
  end

  assign blk_ready    = blk_ready_q;
  assign iv_load      = iv_load_q;
  assign wk_load      = wk_load_q;
  assign round_en     = round_en_q;
  assign round_idx    = round_idx_q;
  assign w_sel        = w_sel_q;
  assign h_update     = h_update_q;
  assign digest_valid = digest_valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// tb/tb_sha256_round_ctrl.sv - self-checking bench for sha256_round_ctrl
module tb_sha256_round_ctrl;

  typedef logic [0:7][31:0] w8_t;

  logic       CLK = 1'b0;
  logic       RST;
  logic       blk_valid, blk_first, blk_last, abort, digest_ready;
  logic       blk_ready, iv_load, wk_load, round_en, w_sel, h_update, digest_valid, busy;
  logic [5:0] round_idx;
  logic [13:0] obs;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  sha256_round_ctrl #(.NUM_ROUNDS(64), .IDX_W(6)) dut (
    .CLK(CLK), .RST(RST),
    .blk_valid(blk_valid), .blk_first(blk_first), .blk_last(blk_last), .blk_ready(blk_ready),
    .abort(abort), .iv_load(iv_load), .wk_load(wk_load), .round_en(round_en),
    .round_idx(round_idx), .w_sel(w_sel), .h_update(h_update),
    .digest_valid(digest_valid), .digest_ready(digest_ready), .busy(busy)
  );

  assign obs = {blk_ready, iv_load, wk_load, round_en, w_sel, h_update, digest_valid, busy, round_idx};

  localparam w8_t IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam w8_t ABC_DIGEST = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  localparam w8_t TWO_DIGEST = {32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
                                32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [13:0] IDLE_VEC = 14'b1_0000000_000000;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] expand(input logic [31:0] w2, w7, w15, w16);
    logic [31:0] s0, s1;
    s0 = rotr(w15, 7) ^ rotr(w15, 18) ^ (w15 >> 3);
    s1 = rotr(w2, 17) ^ rotr(w2, 19) ^ (w2 >> 10);
    return s1 + w7 + s0 + w16;
  endfunction

  function automatic w8_t sha_round(input w8_t s, input logic [31:0] k, input logic [31:0] w);
    logic [31:0] t1, t2;
    t1 = s[7] + (rotr(s[4], 6) ^ rotr(s[4], 11) ^ rotr(s[4], 25)) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + k + w;
    t2 = (rotr(s[0], 2) ^ rotr(s[0], 13) ^ rotr(s[0], 22)) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
    return {t1 + t2, s[0], s[1], s[2], s[3] + t1, s[4], s[5], s[6]};
  endfunction

  function automatic w8_t add8(input w8_t a, input w8_t b);
    w8_t r;
    for (int i = 0; i < 8; i++) r[i] = a[i] + b[i];
    return r;
  endfunction

  function automatic w8_t compress(input w8_t h, input logic [31:0] m [16]);
    logic [31:0] w [64];
    w8_t s;
    for (int t = 0; t < 16; t++) w[t] = m[t];
    for (int t = 16; t < 64; t++) w[t] = expand(w[t-2], w[t-7], w[t-15], w[t-16]);
    s = h;
    for (int t = 0; t < 64; t++) s = sha_round(s, K[t], w[t]);
    return add8(h, s);
  endfunction

  // Expected outputs c cycles after the accepting edge (no abort, DONE not yet released).
  function automatic logic [13:0] exp_vec(input int c, input bit first, input bit last);
    logic [13:0] v;
    v = IDLE_VEC;
    if (c == 1)
      v = {1'b0, first, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0};
    else if (c >= 2 && c <= 65)
      v = {1'b0, 1'b0, 1'b0, 1'b1, ((c - 2) >= 16), 1'b0, 1'b0, 1'b1, 6'(c - 2)};
    else if (c == 66)
      v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd0};
    else if (last)
      v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0};
    return v;
  endfunction

  // Datapath model driven only by the controller strobes.
  logic [31:0] msg  [16];
  logic [31:0] wbuf [64];
  w8_t         hreg, wk;
  int          hupd_cnt = 0;
  logic [31:0] w_now;

  always_comb begin
    w_now = msg[round_idx[3:0]];
    if (w_sel)
      w_now = expand(wbuf[round_idx - 6'd2], wbuf[round_idx - 6'd7],
                     wbuf[round_idx - 6'd15], wbuf[round_idx - 6'd16]);
  end

  always @(posedge CLK) begin
    if (iv_load) begin
      hreg <= IV;
      wk   <= IV;
    end else if (wk_load) begin
      wk <= hreg;
    end else if (round_en) begin
      wbuf[round_idx] <= w_now;
      wk <= sha_round(wk, K[round_idx], w_now);
    end
    if (h_update) begin
      hreg     <= add8(hreg, wk);
      hupd_cnt <= hupd_cnt + 1;
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (blk_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_ready timeout blk_ready=%b exp 1", blk_ready);
    end
  endtask

  // Offers one block and checks every cycle until IDLE is reached again.
  // abort_c: cycle (1..66) in which abort is raised, or -1.
  // hold: cycle 66+hold raises digest_ready (last blocks only).
  task automatic send_block(input bit first, input bit last, input int abort_c,
                            input int hold, input bit noise);
    bit ok;
    logic [13:0] exp;
    wait_ready(ok);
    if (!ok) return;
    blk_valid = 1'b1; blk_first = first; blk_last = last;
    for (int c = 1; c < 300; c++) begin
      @(negedge CLK);
      exp = (last && c > 66 + hold) ? IDLE_VEC : exp_vec(c, first, last);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL block_cycle c=%0d f=%0b l=%0b got %h exp %h", c, first, last, obs, exp);
      end
      if ((!last && c == 67) || (last && c == 67 + hold)) break;
      blk_valid    = (noise && (c <= 65 || c < 66 + hold)) ? 1'($urandom_range(0, 1)) : 1'b0;
      blk_first    = 1'($urandom_range(0, 1));
      blk_last     = 1'($urandom_range(0, 1));
      digest_ready = (noise && c <= 65) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (last && c == 66 + hold) begin
        digest_ready = 1'b1;
        blk_valid    = 1'b0;
      end
      if (c == abort_c) begin
        abort = 1'b1; blk_valid = 1'b0; digest_ready = 1'b0;
        @(negedge CLK);
        checks++;
        if (obs !== IDLE_VEC) begin
          errors++;
          $display("FAIL abort_idle c=%0d got %h exp %h", c, obs, IDLE_VEC);
        end
        break;
      end
    end
    abort = 1'b0; blk_valid = 1'b0; digest_ready = 1'b0;
  endtask

  task automatic load_abc();
    for (int i = 0; i < 16; i++) msg[i] = 32'h0;
    msg[0]  = 32'h61626380;
    msg[15] = 32'h00000018;
  endtask

  task automatic load_random();
    for (int i = 0; i < 16; i++) msg[i] = $urandom;
  endtask

  task automatic check_digest(input string name, input w8_t exp);
    checks++;
    if (hreg !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, hreg, exp);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      blk_valid = 1'($urandom_range(0, 1)); digest_ready = 1'($urandom_range(0, 1));
    end
    blk_valid = 1'b0; digest_ready = 1'b0;
    @(negedge CLK);
    checks++;
    if (obs !== IDLE_VEC) begin
      errors++;
      $display("FAIL reset_vec got %h exp %h", obs, IDLE_VEC);
    end
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (busy !== 1'b0 || blk_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle busy=%b blk_ready=%b exp 0/1", busy, blk_ready);
    end
  endtask

  task automatic test_single_abc();
    load_abc();
    send_block(1'b1, 1'b1, -1, 11, 1'b1);
    check_digest("abc_digest", ABC_DIGEST);
  endtask

  task automatic test_two_block();
    for (int i = 0; i < 14; i++) msg[i] = 32'h61626364 + (i * 32'h01010101);
    msg[14] = 32'h80000000; msg[15] = 32'h0;
    send_block(1'b1, 1'b0, -1, 0, 1'b1);
    for (int i = 0; i < 15; i++) msg[i] = 32'h0;
    msg[15] = 32'h000001c0;
    send_block(1'b0, 1'b1, -1, $urandom_range(1, 5), 1'b1);
    check_digest("two_block_digest", TWO_DIGEST);
  endtask

  task automatic test_abort();
    int hc;
    load_random();
    hc = hupd_cnt;
    send_block(1'b1, 1'b1, 32, 1, 1'b1);
    checks++;
    if (hupd_cnt !== hc) begin
      errors++;
      $display("FAIL abort_round30_hupd got %0d exp %0d", hupd_cnt, hc);
    end
    load_abc();
    send_block(1'b1, 1'b1, -1, 2, 1'b0);
    check_digest("abc_after_abort", ABC_DIGEST);
    hc = hupd_cnt;
    send_block(1'b1, 1'b1, 66, 1, 1'b0);
    checks++;
    if (hupd_cnt !== hc + 1) begin
      errors++;
      $display("FAIL abort_update_hupd got %0d exp %0d", hupd_cnt, hc + 1);
    end
  endtask

  task automatic test_abort_with_valid();
    bit ok;
    wait_ready(ok);
    blk_valid = 1'b1; blk_first = 1'b1; blk_last = 1'b1; abort = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      checks++;
      if (obs !== IDLE_VEC) begin
        errors++;
        $display("FAIL abort_with_valid got %h exp %h", obs, IDLE_VEC);
      end
    end
    blk_valid = 1'b0; abort = 1'b0;
  endtask

  task automatic test_rst_mid();
    bit ok;
    wait_ready(ok);
    blk_valid = 1'b1; blk_first = 1'b1; blk_last = 1'b1;
    @(negedge CLK);
    blk_valid = 1'b0;
    repeat (20) @(negedge CLK);
    checks++;
    if (round_en !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre round_en=%b exp 1", round_en);
    end
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    checks++;
    if (obs !== IDLE_VEC) begin
      errors++;
      $display("FAIL rst_mid got %h exp %h", obs, IDLE_VEC);
    end
  endtask

  task automatic test_random();
    w8_t h_start;
    bit  first, last;
    int  abort_c;
    for (int n = 0; n < 8; n++) begin
      load_random();
      first   = (n == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      last    = 1'($urandom_range(0, 1));
      abort_c = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 66)) : -1;
      h_start = first ? IV : hreg;
      send_block(first, last, abort_c, $urandom_range(1, 6), 1'b1);
      if (abort_c < 0) check_digest("random_digest", compress(h_start, msg));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1'b1; blk_valid = 1'b0; blk_first = 1'b0; blk_last = 1'b0;
    abort = 1'b0; digest_ready = 1'b0;
    test_reset();
    test_single_abc();
    test_two_block();
    test_abort();
    test_abort_with_valid();
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_round_ctrl.md
Name: sha256_round_ctrl

Overview:
- Control FSM that sequences the SHA-256 working-register datapath (A..H, including the G register) and the H-digest registers.
- Accepts one 512-bit message block per handshake and issues the IV/working-register load.
- Steps 64 compression rounds, driving round enables, the K/W index and the W-source select.
- Triggers the final digest accumulation; presents digest_valid after the last block of a message.

Parameters:
NUM_ROUNDS, 64, compression rounds per block
IDX_W, 6, width of round_idx (must satisfy 2**IDX_W >= NUM_ROUNDS)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, synchronous, active-high
blk_valid  input  1  message block available from padder
blk_first  input  1  block is first of message (sampled with blk_valid)
blk_last  input  1  block is last of message (sampled with blk_valid)
blk_ready  output  1  controller can accept a block
abort  input  1  synchronous cancel of current operation
iv_load  output  1  load SHA-256 IV into H and working registers
wk_load  output  1  load working registers A..H from H registers
round_en  output  1  start/enable strobe to working registers and W scheduler
round_idx  output  IDX_W  current round t (K-ROM and W index)
w_sel  output  1  0: W from message words (t<16); 1: from expander
h_update  output  1  H[i] <= H[i] + working[i]
digest_valid  output  1  digest in H registers is final
digest_ready  input  1  consumer has taken the digest
busy  output  1  high in any state other than IDLE

Behaviour:
- States: IDLE, INIT, ROUND, UPDATE, DONE. State encoding lives in the shared package.
- All outputs are Moore-decoded from registered state, round counter and captured flags. There are no combinational paths from inputs to outputs.
- Reset (RST high at a CLK edge):
  - state=IDLE, counter=0, flags=0.
  - blk_ready=1; all other outputs=0; round_idx=0.
- IDLE:
  - blk_ready=1.
  - On blk_valid=1 and abort=0: capture blk_first and blk_last, then go to INIT.
- INIT (1 cycle):
  - wk_load=1.
  - iv_load=captured first. The datapath muxes IV into both H and A..H in this same cycle.
  - Counter cleared to 0.
- ROUND (exactly NUM_ROUNDS cycles):
  - round_en=1; round_idx=counter; w_sel=(counter>=16).
  - Counter increments each cycle.
  - When counter==NUM_ROUNDS-1, go to UPDATE. The counter never wraps inside ROUND.
- UPDATE (1 cycle):
  - h_update=1.
  - Next state is DONE if captured last=1, else IDLE.
- DONE:
  - digest_valid=1, held until digest_ready=1.
  - On digest_ready=1, go to IDLE next cycle. No new block is accepted while in DONE.
- Latency, with the block accepted at edge 0:
  - INIT in cycle 1.
  - ROUND in cycles 2..65 (round_idx 0..63).
  - UPDATE in cycle 66.
  - digest_valid first seen in cycle 67 (last block), or blk_ready=1 again in cycle 67 (non-last block).
- Multi-block: a non-first block skips iv_load; wk_load copies the accumulated H.
- abort=1 in any state returns to IDLE next cycle with no h_update and flags cleared.
  - abort together with blk_valid in IDLE: abort wins, the block is not accepted.
  - abort during UPDATE: the h_update of that cycle still occurs (it is already decoded); the state still goes to IDLE.
- RST mid-operation has the same effect as reset from power-up. No partial-state retention.
- blk_first=1 on a block while a message is in progress is legal: that block restarts from IV.
- digest_ready while not in DONE is ignored.
- blk_valid with blk_ready=0 is ignored; the padder holds its block.

Decomposition:
- Shared package sha256_pkg:
  - state enum (IDLE/INIT/ROUND/UPDATE/DONE)
  - NUM_ROUNDS default and the W_MSG_WORDS=16 constant
  - the IV constants used by the datapath mux
- One sub-module: sha256_round_cnt.
  - Clear/enable counter, IDX_W bits, with a terminal-count flag tc = (count==NUM_ROUNDS-1).
  - Uses the same CLK/RST conventions.

Test Plan:
- Reset then idle: RST high for 2 cycles -> blk_ready=1, busy=0, all strobes 0, round_idx=0.
- Single-block message "abc" (first=1, last=1):
  - iv_load=wk_load=1 in cycle 1.
  - round_en high for exactly 64 cycles, round_idx 0..63; w_sel rises when round_idx=16.
  - h_update in cycle 66; digest_valid in cycle 67.
  - H = ba7816bf...f20015ad.
- Two-block message (first=1/last=0, then first=0/last=1):
  - iv_load only on block 1; no digest_valid after block 1; blk_ready=1 in cycle 67.
  - Digest matches the 56-byte NIST vector 248d6a61...19db06c1.
- DONE hold: digest_ready held low 10 cycles -> digest_valid stays 1, blk_valid ignored. digest_ready=1 -> IDLE next cycle.
- abort at round_idx=30 -> IDLE next cycle, no h_update. A following single-block "abc" still yields the correct digest.
- abort and blk_valid in the same IDLE cycle -> block not accepted, busy stays 0. RST asserted mid-ROUND -> outputs equal the reset values next cycle.
